// File: rtl/uart_tx_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_queue : 8N1 UART transmitter fed from a circular byte queue
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_queue #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_LOG2   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  tx
);

  localparam int CNT_W  = DEPTH_LOG2 + 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]     BAUD_ONE  = BAUD_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state_q,  state_d;
  logic [BAUD_W-1:0]     baud_q,   baud_d;
  logic [2:0]            bit_q,    bit_d;
  logic [7:0]            shift_q,  shift_d;
  logic                  tx_q,     tx_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic [7:0]            mem_q [DEPTH];

  logic baud_done;
  logic push;
  logic pop;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = wr_en & full;
  assign busy      = (state_q != IDLE);
  assign tx        = tx_q;

  assign baud_done = (baud_q == BAUD_LAST);

  // full is judged on the pre-pop count, so a same-cycle pop never frees a slot
  assign push = wr_en & ~full;
  assign pop  = ~empty & ((state_q == IDLE) | ((state_q == STOP) & baud_done));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (pop) begin
          state_d = START;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          bit_d  = '0;
          if (pop) begin
            state_d = START;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left uncleared by reset; count/pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// tb_uart_tx_queue : directed + randomized check of uart_tx_queue against a
// byte-queue / frame-time model and a line-sampling receiver.
module tb_uart_tx_queue;

  localparam int CPB   = 4;
  localparam int DL2   = 3;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic           clk     = 1'b0;
  logic           reset   = 1'b0;
  logic           wr_en   = 1'b0;
  logic [7:0]     wr_data = 8'h00;
  logic           full, empty, overflow, busy, tx;
  logic [DL2:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_queue #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: bytes waiting in the queue, plus position inside the current frame
  logic [7:0] mq[$];
  int         m_t = -1;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk or negedge reset) begin
    bit was_full;
    bit do_pop;
    if (!reset) begin
      mq.delete();
      m_t = -1;
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = 1'b0;
      if (m_t < 0) begin
        do_pop = (mq.size() > 0);
      end else if (m_t == FRAME - 1) begin
        do_pop = (mq.size() > 0);
        if (!do_pop) m_t = -1;
      end else begin
        m_t++;
      end
      if (do_pop) begin
        m_byte = mq.pop_front();
        m_t    = 0;
      end
      if (wr_en && !was_full) mq.push_back(wr_data);
    end
  end

  function automatic int exp_tx();
    if (m_t < 0)       return 1;
    if (m_t < CPB)     return 0;
    if (m_t < 9 * CPB) return int'(m_byte[(m_t - CPB) / CPB]);
    return 1;
  endfunction

  always @(negedge clk) begin
    check("tx",       int'(tx),       exp_tx());
    check("busy",     int'(busy),     (m_t >= 0) ? 1 : 0);
    check("count",    int'(count),    mq.size());
    check("empty",    int'(empty),    (mq.size() == 0) ? 1 : 0);
    check("full",     int'(full),     (mq.size() == DEPTH) ? 1 : 0);
    check("overflow", int'(overflow), (wr_en && mq.size() == DEPTH) ? 1 : 0);
  end

  // Line receiver: samples each bit in the middle of its cell
  logic [7:0] rx_q[$];
  logic [7:0] rx_exp[$];
  logic [7:0] rx_byte;

  initial begin
    forever begin
      @(negedge clk);
      if (reset && tx == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_byte[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back(rx_byte);
      end
    end
  end

  function automatic void check_rx(input string name);
    check({name, "_len"}, rx_q.size(), rx_exp.size());
    for (int i = 0; i < rx_exp.size() && i < rx_q.size(); i++)
      check(name, int'(rx_q[i]), int'(rx_exp[i]));
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || !empty) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, int'(!busy && empty), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic           tx_s    [90];
    logic           busy_s  [90];
    logic           empty_s [90];
    logic [DL2:0]   cnt_s   [90];
    logic [9:0]     frame;
    int             bad;
    int             nbusy;
    int             n;

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",       int'(tx),       1);
    check("rst_busy",     int'(busy),     0);
    check("rst_empty",    int'(empty),    1);
    check("rst_full",     int'(full),     0);
    check("rst_count",    int'(count),    0);
    check("rst_overflow", int'(overflow), 0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Single byte 0xA5
    wr_en = 1'b1; wr_data = 8'hA5;
    @(posedge clk); #1;
    wr_en = 1'b0;
    for (int j = 0; j < 45; j++) begin
      @(negedge clk);
      tx_s[j] = tx; busy_s[j] = busy;
    end
    check("a5_tx_before_start", int'(tx_s[0]), 1);
    check("a5_busy_before",     int'(busy_s[0]), 0);
    frame = {1'b1, 8'hA5, 1'b0};
    bad = 0;
    for (int g = 0; g < 10; g++)
      for (int k = 0; k < CPB; k++)
        if (tx_s[1 + CPB * g + k] != frame[g]) bad++;
    check("a5_frame_bits", bad, 0);
    nbusy = 0;
    for (int j = 0; j < 45; j++) nbusy += int'(busy_s[j]);
    check("a5_busy_cycles", nbusy, 40);
    check("a5_idle_tx", int'(tx_s[41]), 1);
    wait_idle("a5_idle", 200);

    // Back-to-back 0x00, 0xFF
    wr_en = 1'b1; wr_data = 8'h00;
    @(posedge clk); #1;
    wr_data = 8'hFF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    for (int j = 0; j < 85; j++) begin
      @(negedge clk);
      tx_s[j] = tx; busy_s[j] = busy; empty_s[j] = empty; cnt_s[j] = count;
    end
    bad = 0;
    nbusy = 0;
    for (int j = 0; j < 85; j++) begin
      n = j + 1;
      if (tx_s[j] != ((n <= 36) ? 1'b0 : (n <= 40) ? 1'b1 : (n <= 44) ? 1'b0 : 1'b1)) bad++;
      nbusy += int'(busy_s[j]);
    end
    check("b2b_tx_pattern", bad, 0);
    check("b2b_busy_cycles", nbusy, 80);
    check("b2b_second_start", int'(tx_s[40]), 0);
    check("b2b_count_one", int'(cnt_s[0]), 1);
    check("b2b_not_empty_before_pop", int'(empty_s[39]), 0);
    check("b2b_empty_after_pop", int'(empty_s[40]), 1);
    check("b2b_idle_after", int'(busy_s[80]), 0);
    wait_idle("b2b_idle", 200);

    // Full / overflow, then overflow on the pop cycle
    rx_q.delete();
    wr_en = 1'b1; wr_data = 8'h30;
    @(posedge clk); #1;
    for (int i = 1; i <= 9; i++) begin
      wr_data = 8'(i);
      if (i == 9) begin
        @(negedge clk);
        check("ovf_pulse", int'(overflow), 1);
        check("ovf_full",  int'(full),     1);
        check("ovf_count", int'(count),    8);
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("ovf_one_cycle", int'(overflow), 0);
    check("ovf_count_kept", int'(count), 8);
    @(posedge clk);
    repeat (30) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    check("pop_wr_ovf", int'(overflow), 1);
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("pop_wr_count7", int'(count), 7);
    check("pop_wr_busy", int'(busy), 1);
    @(posedge clk); #1;
    wait_idle("ovf_drain", 500);
    rx_exp.delete();
    rx_exp.push_back(8'h30);
    for (int i = 1; i <= 8; i++) rx_exp.push_back(8'(i));
    check_rx("ovf_rx");

    // Paced stream across pointer wrap
    rx_q.delete();
    rx_exp.delete();
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 8'(16 + i);
      rx_exp.push_back(8'(16 + i));
      @(posedge clk); #1;
      wr_en = 1'b0;
      repeat ($urandom_range(29, 44)) @(posedge clk);
      #1;
    end
    wait_idle("wrap_idle", 1000);
    check_rx("wrap_rx");

    // Reset mid-frame (data bit 3) with three bytes queued
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    check("pre_reset_count", int'(count), 3);
    check("pre_reset_busy",  int'(busy),  1);
    reset = 1'b0;
    #1;
    check("mid_rst_tx",    int'(tx),    1);
    check("mid_rst_busy",  int'(busy),  0);
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_count", int'(count), 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    bad = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_rst_quiet", bad, 0);
    rx_q.delete();
    rx_exp.delete();
    @(posedge clk); #1;
    wr_en = 1'b1; wr_data = 8'h66;
    rx_exp.push_back(8'h66);
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_idle("post_rst_idle", 200);
    check_rx("post_rst_rx");

    // Random traffic with one asynchronous reset pulse
    for (int c = 0; c < 900; c++) begin
      wr_en   = ($urandom_range(0, 9) < 3);
      wr_data = 8'($urandom);
      if (c == 450) begin
        #3 reset = 1'b0;
        #4 reset = 1'b1;
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    wait_idle("rand_idle", 600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, meaning log2 of queue depth (DEPTH = 8 bytes).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  request to enqueue wr_data this cycle.
REQ-006 SHALL have port wr_data  input  8  byte to enqueue.
REQ-007 SHALL have port full  output  1  queue holds DEPTH bytes.
REQ-008 SHALL have port empty  output  1  queue holds 0 bytes.
REQ-009 SHALL have port count  output  DEPTH_LOG2+1  bytes currently queued (0..DEPTH), excluding the byte being shifted out.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse: wr_en rejected because full.
REQ-011 SHALL have port busy  output  1  serializer is in a non-IDLE state.
REQ-012 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-013 SHALL frame each byte as 8N1: start bit 0, data bits LSB first, one stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-014 SHALL implement a circular queue of DEPTH bytes with DEPTH_LOG2-bit read/write pointers wrapping DEPTH-1 -> 0.
REQ-015 SHALL accept a write only when wr_en=1 and full=0, sampled before any same-cycle pop; a pop in the same cycle does not make room for a write.
REQ-016 SHALL, on wr_en=1 with full=1, discard wr_data, leave queue state unchanged, and assert overflow for that one cycle.
REQ-017 SHALL, on a simultaneous accepted write and pop, leave count unchanged and advance both pointers.
REQ-018 SHALL use FSM states IDLE, START, DATA, STOP; busy=0 only in IDLE.
REQ-019 SHALL, in IDLE with empty=0, pop the head byte into an 8-bit shift register at the next edge, enter START, and drive tx=0.
REQ-020 SHALL, for a write into an empty queue while IDLE, drive tx low starting one cycle after the write edge.
REQ-021 SHALL transition START -> DATA after CLKS_PER_BIT cycles; in DATA, shift out 8 bits, advancing the bit index after every CLKS_PER_BIT cycles; after bit 7, enter STOP with tx=1.
REQ-022 SHALL, at the end of STOP, pop and enter START directly if empty=0 (frames back-to-back, exactly 10*CLKS_PER_BIT cycles each), else enter IDLE.
REQ-023 SHALL use a baud counter of ceil(log2(CLKS_PER_BIT)) bits, cleared on every state or bit change.
REQ-024 SHALL drive tx from a register (glitch-free, no combinational path from wr_en to tx).
REQ-025 SHALL derive full, empty, and count combinationally from registered pointers and count only.

Reset
REQ-026 SHALL, while reset=0, immediately force: FSM=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, busy=0, tx=1, baud and bit counters=0.
REQ-027 SHALL, on reset asserted mid-frame, abort the frame, discard all queued bytes, and hold tx=1 with no partial stop bit.
REQ-028 SHALL begin normal operation on the first rising clk edge after reset deasserts; queue contents need not be cleared.

Verification (CLKS_PER_BIT=4, DEPTH_LOG2=3)
REQ-029 SHALL cover a single byte: write 0xA5 into an idle, empty queue -> tx low one cycle later for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then tx=1 for 4 cycles; busy=1 for exactly 40 cycles.
REQ-030 SHALL cover back-to-back frames: write 0x00 then 0xFF on consecutive cycles -> two 40-cycle frames with no idle gap between stop bit and second start bit; empty=1 after the second pop.
REQ-031 SHALL cover full and overflow: while the first frame transmits, write 9 more bytes 0x01..0x09 -> 0x01..0x08 accepted, full=1, count=8; 0x09 rejected with a one-cycle overflow pulse; 0x09 never appears on tx.
REQ-032 SHALL cover simultaneous pop and write: with count=8, write 0x55 on the cycle a frame ends and pops -> write rejected (overflow=1), count=7.
REQ-033 SHALL cover pointer wrap-around: send 20 bytes 0x10..0x23 paced so the queue never fills -> all 20 bytes are received in order on tx by a model receiver.
REQ-034 SHALL cover reset mid-frame: assert reset=0 during DATA bit 3 with 3 bytes queued -> tx=1, busy=0, empty=1, count=0 immediately; no further frames after release until a new write.
